// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, default parameters and instruction field positions
package fetch_pkg;
  typedef enum logic [1:0] {BOOT, RUN, HALTED, FAULT} state_t;
  localparam logic [31:0] DEF_RESET_PC = 32'd0;
  localparam int DEF_MEM_WORDS = 32;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;
  localparam int IMM_W = IMM_MSB - IMM_LSB + 1;
endpackage

// File: rtl/next_pc_calc.sv
// next_pc_calc: jump / taken-branch target for the presented instruction
module next_pc_calc
  import fetch_pkg::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] instr_pc,
  input  logic        jump,
  output logic [31:0] target
);
  assign target = jump ? {instr_pc[OPC_MSB:OPC_LSB], instr[JIDX_MSB:JIDX_LSB]}
                       : instr_pc + 32'd1 + {{(32-IMM_W){instr[IMM_MSB]}}, instr[IMM_MSB:IMM_LSB]};
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with stall, redirect, halt and out-of-range fault
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
  parameter int          MEM_WORDS = DEF_MEM_WORDS
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Jump,
  input  logic        BranchTaken,
  input  logic        Halt,
  input  logic        Resume,
  output logic [31:0] MemAddress,
  input  logic [31:0] MemData,
  output logic [31:0] Instr,
  output logic [31:0] InstrPC,
  output logic        InstrValid,
  output logic        Fault
);
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS);
  state_t state, state_nx;
  logic [31:0] pc, issued_pc, target;
  logic redirect, want, fetch, flt;
  assign Instr = MemData;
  assign InstrPC = issued_pc;
  next_pc_calc u_calc (
    .instr   (MemData),
    .instr_pc(issued_pc),
    .jump    (Jump),
    .target  (target)
  );
  // fetch address selection, fetch/fault decision and next state
  always_comb begin
    redirect = InstrValid && state == RUN && (Jump || BranchTaken);
    MemAddress = redirect ? target : (Stall && state == RUN) ? issued_pc : pc;
    want = (state == RUN && !Halt) || (state == HALTED && Resume);
    fetch = want && MemAddress < LIMIT;
    flt = want && MemAddress >= LIMIT;
    state_nx = state == BOOT ? RUN
             : flt ? FAULT
             : (state == RUN && Halt) ? HALTED
             : (state == HALTED && Resume) ? RUN
             : state;
  end
  // state, address registers, valid and sticky fault
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= BOOT;
      pc <= RESET_PC;
      issued_pc <= RESET_PC;
      InstrValid <= 1'b0;
      Fault <= 1'b0;
    end else begin
      state <= state_nx;
      InstrValid <= fetch;
      Fault <= Fault | flt;
      if (fetch) begin
        issued_pc <= MemAddress;
        pc <= MemAddress + 32'd1;
      end else if (Halt && redirect) begin
        pc <= target;
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized traffic against a behavioural fetch model
module tb_fetch_unit;
  logic Clk, Reset, Stall, Jump, BranchTaken, Halt, Resume;
  logic [31:0] MemAddress, MemData, Instr, InstrPC;
  logic InstrValid, Fault;
  logic [31:0] mem [32];
  int n_chk = 0;
  int n_pass = 0;
  string m_mode;
  bit m_valid, m_fault;
  logic [31:0] m_ipc, m_next;

  fetch_unit #(.RESET_PC(32'd0), .MEM_WORDS(32)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Jump(Jump), .BranchTaken(BranchTaken),
    .Halt(Halt), .Resume(Resume), .MemAddress(MemAddress), .MemData(MemData),
    .Instr(Instr), .InstrPC(InstrPC), .InstrValid(InstrValid), .Fault(Fault)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // instruction memory with one-cycle registered read
  always @(posedge Clk) MemData <= (MemAddress < 32) ? mem[MemAddress[4:0]] : 32'hDEADBEEF;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    m_mode = "boot";
    m_valid = 0;
    m_fault = 0;
    m_ipc = 0;
    m_next = 0;
  endtask

  task automatic step_reset();
    @(negedge Clk);
    Reset = 1;
    Stall = 1'($urandom_range(0, 1));
    Jump = 1'($urandom_range(0, 1));
    BranchTaken = 1'($urandom_range(0, 1));
    Halt = 1'($urandom_range(0, 1));
    Resume = 1'($urandom_range(0, 1));
    #1;
    check("rst_addr", MemAddress, 32'd0);
    check("rst_valid", 32'(InstrValid), 32'd0);
    check("rst_fault", 32'(Fault), 32'd0);
    model_reset();
  endtask

  task automatic step(input bit st, input bit j, input bit b, input bit h, input bit r);
    logic [31:0] w, tgt, addr;
    bit run, redir, want;
    @(negedge Clk);
    Reset = 0; Stall = st; Jump = j; BranchTaken = b; Halt = h; Resume = r;
    #1;
    run = (m_mode == "run");
    w = mem[m_ipc[4:0]];
    redir = run && m_valid && (j || b);
    tgt = j ? {m_ipc[31:26], w[25:0]} : 32'(longint'(m_ipc) + 1 + longint'($signed(w[15:0])));
    addr = redir ? tgt : (run && st) ? m_ipc : m_next;
    check("addr", MemAddress, addr);
    check("valid", 32'(InstrValid), 32'(m_valid));
    check("fault", 32'(Fault), 32'(m_fault));
    if (m_valid) begin
      check("ipc", InstrPC, m_ipc);
      check("instr", Instr, w);
    end
    want = (run && !h) || (m_mode == "halted" && r);
    if (m_mode == "boot") begin
      m_mode = "run";
      m_valid = 0;
    end else if (want) begin
      if (addr >= 32) begin
        m_mode = "fault";
        m_fault = 1;
        m_valid = 0;
      end else begin
        m_mode = "run";
        m_valid = 1;
        m_ipc = addr;
        m_next = addr + 1;
      end
    end else begin
      m_valid = 0;
      if (run && h) begin
        m_mode = "halted";
        if (redir) m_next = tgt;
      end
    end
  endtask

  task automatic run_until(input logic [31:0] a);
    int k = 0;
    while (!(m_valid && m_ipc == a) && k < 64) begin
      step(0, 0, 0, 0, 0);
      k++;
    end
    if (k == 64) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] w;
    int k;
    Reset = 1; Stall = 0; Jump = 0; BranchTaken = 0; Halt = 0; Resume = 0;
    for (int i = 0; i < 32; i++) begin
      w = $urandom();
      w[25:16] = 10'd0;
      k = $urandom_range(1, 8);
      w[15:0] = ($urandom_range(0, 4) == 0) ? 16'(-k) : 16'($urandom_range(0, 31));
      mem[i] = w;
    end
    mem[10] = {6'b101101, 26'd16};
    mem[18] = 32'h0000FFFD;
    model_reset();
    step_reset();
    step_reset();
    step(0, 0, 0, 0, 0);
    check("boot_valid", 32'(InstrValid), 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    check("first_pc", InstrPC, 32'd0);
    check("first_valid", 32'(InstrValid), 32'd1);
    step(0, 0, 0, 0, 0);
    check("seq_pc1", InstrPC, 32'd1);
    run_until(3);
    step(0, 0, 0, 1, 0);
    check("halt_pc", InstrPC, 32'd3);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0);
      check("halted_valid", 32'(InstrValid), 32'd0);
    end
    step(0, 0, 0, 0, 1);
    check("resume_valid", 32'(InstrValid), 32'd0);
    step(0, 0, 0, 0, 0);
    check("resume_pc", InstrPC, 32'd4);
    check("resume_vld", 32'(InstrValid), 32'd1);
    run_until(5);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0, 0, 0);
      check("stall_addr", MemAddress, 32'd5);
      check("stall_pc", InstrPC, 32'd5);
    end
    step(0, 0, 0, 0, 0);
    check("stall_rel5", InstrPC, 32'd5);
    step(0, 0, 0, 0, 0);
    check("stall_rel6", InstrPC, 32'd6);
    run_until(10);
    step(0, 1, 0, 0, 0);
    check("jump_addr", MemAddress, 32'd16);
    step(0, 0, 0, 0, 0);
    check("jump_pc", InstrPC, 32'd16);
    run_until(18);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    check("branch_pc", InstrPC, 32'd16);
    run_until(31);
    step(0, 0, 0, 0, 0);
    check("last_pc", InstrPC, 32'd31);
    step(0, 0, 0, 0, 0);
    check("fault_set", 32'(Fault), 32'd1);
    check("fault_vld", 32'(InstrValid), 32'd0);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    check("fault_sticky", 32'(Fault), 32'd1);
    step_reset();
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 59) == 0 || (m_mode == "fault" && $urandom_range(0, 7) == 0))
        step_reset();
      else
        step($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
             $urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 0, word address of the first instruction fetched after reset.
REQ-002 SHALL have parameter MEM_WORDS, default 32, number of valid instruction-memory words.
REQ-003 SHALL have port Clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port Stall  in  1  consumer did not accept the presented instruction this cycle.
REQ-006 SHALL have port Jump  in  1  presented instruction is a jump; take it.
REQ-007 SHALL have port BranchTaken  in  1  presented instruction is a taken conditional branch.
REQ-008 SHALL have port Halt  in  1  stop issuing fetches.
REQ-009 SHALL have port Resume  in  1  restart fetching from HALTED.
REQ-010 SHALL have port MemAddress  out  32  word address to instruction memory.
REQ-011 SHALL have port MemData  in  32  instruction-memory read data; one-cycle registered latency.
REQ-012 SHALL have port Instr  out  32  presented instruction, driven directly from MemData.
REQ-013 SHALL have port InstrPC  out  32  word address of Instr.
REQ-014 SHALL have port InstrValid  out  1  Instr/InstrPC are valid.
REQ-015 SHALL have port Fault  out  1  sticky out-of-range fetch flag.

Function
REQ-016 SHALL implement states BOOT, RUN, HALTED and FAULT: BOOT->RUN unconditionally; RUN->HALTED on Halt; HALTED->RUN on Resume; RUN->FAULT on an out-of-range fetch; FAULT exits only on Reset.
REQ-017 SHALL keep register PC (next sequential address) and register IssuedPC (address fetched last cycle); InstrPC SHALL equal IssuedPC.
REQ-018 SHALL compute the redirect target from Instr/InstrPC: Jump -> {InstrPC[31:26], Instr[25:0]}; BranchTaken -> InstrPC + 1 + signext(Instr[15:0]), modulo 2^32.
REQ-019 SHALL honour Jump/BranchTaken only when InstrValid=1 and state is RUN; Jump SHALL win when both are high.
REQ-020 SHALL drive MemAddress combinationally: redirect target if redirecting; else IssuedPC if Stall; else PC.
REQ-021 SHALL, in each RUN cycle with an issued fetch, update IssuedPC <= MemAddress and PC <= MemAddress + 1; Stall without redirect SHALL hold PC and IssuedPC and re-fetch IssuedPC.
REQ-022 SHALL give redirect precedence over Stall in the same cycle, so the target is fetched with zero bubble and no wrong-path instruction ever becomes valid.
REQ-023 SHALL set InstrValid in cycle t+1 iff a fetch was issued in cycle t; no fetch SHALL be issued in BOOT, HALTED or FAULT.
REQ-024 SHALL, on Halt in cycle t, present the cycle-t instruction normally, issue no fetch in t, and hold PC.
REQ-025 SHALL, on Resume in cycle u, issue a fetch of PC in u, giving InstrValid=1 in u+1; Resume outside HALTED SHALL be ignored.
REQ-026 SHALL treat a RUN-state MemAddress >= MEM_WORDS as out of range: no fetch issued, Fault <= 1, state -> FAULT, InstrValid=0 thereafter.
REQ-027 SHALL give Halt priority over Jump/BranchTaken/Stall; PC SHALL be updated by a redirect issued in the same cycle as Halt.

Reset
REQ-028 SHALL, while Reset is high, force state BOOT, PC=RESET_PC, IssuedPC=RESET_PC, InstrValid=0, Fault=0, and drive MemAddress=RESET_PC.
REQ-029 SHALL abort any operation, including stall, halt or fault, when Reset is asserted mid-operation; there is no partial-state retention.

Structure
REQ-030 SHALL place the state encoding, RESET_PC/MEM_WORDS defaults and instruction field positions (opcode, jump index, imm16) in shared package fetch_pkg.
REQ-031 SHALL isolate the target arithmetic in a combinational sub-module next_pc_calc.

Verification
REQ-032 SHALL cover this reset case: release Reset with no stall -> BOOT for 1 cycle, then InstrValid=1 with InstrPC 0,1,2,... in consecutive cycles.
REQ-033 SHALL cover this jump case: Jump with Instr[25:0]=16 at InstrPC=10 -> next cycle InstrPC=16 valid, and InstrPC=11 is never valid.
REQ-034 SHALL cover this branch case: BranchTaken with imm 0xFFFD at InstrPC=18 -> next cycle InstrPC=16 valid.
REQ-035 SHALL cover this stall case: Stall high for 3 cycles at InstrPC=5 -> Instr/InstrPC held with MemAddress=5; after release InstrPC=6.
REQ-036 SHALL cover these halt and fault cases:
- Halt at InstrPC=3, Resume 4 cycles later -> InstrValid=0 throughout, then InstrPC=4.
- Run sequentially past 31 with MEM_WORDS=32 -> after InstrPC=31, Fault=1 sticky and InstrValid=0 until Reset.
